mem_arbiter: RTL and testbench

- Shares one memory port between the instruction fetch requester (I) and the load/store requester (D).
- Both sides use the req/addr_ok/data_ok split-transaction handshake.
- Forwards one granted request per cycle to the memory and tracks outstanding transactions in an in-order owner queue. Each data_ok and its rdata return to the requester that issued the transaction.
- Sits between the fetch unit, the load/store unit and the single-port memory/bus bridge.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one split-transaction memory port between fetch (I) and
//            load/store (D), routing in-order responses back via an owner queue.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iram_req,
    input  logic              iram_write,
    input  logic [XLEN/8-1:0] iram_wstrb,
    input  logic [XLEN-1:0]   iram_addr,
    input  logic [XLEN-1:0]   iram_wdata,
    output logic              iram_addr_ok,
    output logic              iram_data_ok,
    output logic [XLEN-1:0]   iram_rdata,
    input  logic              dram_req,
    input  logic              dram_write,
    input  logic [XLEN/8-1:0] dram_wstrb,
    input  logic [XLEN-1:0]   dram_addr,
    input  logic [XLEN-1:0]   dram_wdata,
    output logic              dram_addr_ok,
    output logic              dram_data_ok,
    output logic [XLEN-1:0]   dram_rdata,
    output logic              mem_req,
    output logic              mem_write,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              err
);

    localparam int C_PTR_W   = $clog2(DEPTH);
    localparam int C_CNT_W   = C_PTR_W + 1;
    localparam int C_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CNT_W-1:0]    C_FULL_CNT   = C_CNT_W'(DEPTH);
    localparam logic [C_STARVE_W-1:0] C_STARVE_MAX = C_STARVE_W'(STARVE_LIMIT);

    logic                  r_lock;
    logic                  r_lock_d;
    logic [C_STARVE_W-1:0] r_starve;
    logic [DEPTH-1:0]      r_owner;
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_CNT_W-1:0]    r_count;
    logic                  r_err;

    logic w_gnt_d;
    logic w_gnt_req;
    logic w_sel_d;
    logic w_full;
    logic w_empty;
    logic w_xfer;
    logic w_pop;
    logic w_head_d;
    logic w_lock_req;

    assign w_full  = (r_count == C_FULL_CNT);
    assign w_empty = (r_count == '0);

    // D wins conflicts until I has watched STARVE_LIMIT D transfers go by.
    always_comb begin
        w_gnt_d = dram_req;
        if (r_lock)
            w_gnt_d = r_lock_d;
        else if (iram_req && dram_req)
            w_gnt_d = (r_starve != C_STARVE_MAX);
    end

    assign w_gnt_req  = w_gnt_d ? dram_req : iram_req;
    assign w_sel_d    = w_gnt_d || !(iram_req || dram_req);
    assign w_lock_req = r_lock_d ? dram_req : iram_req;

    assign mem_req   = w_gnt_req && !w_full && !rst;
    assign mem_write = w_sel_d ? dram_write : iram_write;
    assign mem_wstrb = w_sel_d ? dram_wstrb : iram_wstrb;
    assign mem_addr  = w_sel_d ? dram_addr  : iram_addr;
    assign mem_wdata = w_sel_d ? dram_wdata : iram_wdata;

    assign w_xfer       = mem_req && mem_addr_ok;
    assign iram_addr_ok = w_xfer && !w_gnt_d;
    assign dram_addr_ok = w_xfer && w_gnt_d;

    assign w_head_d     = r_owner[r_rd_ptr];
    assign w_pop        = mem_data_ok && !w_empty && !rst;
    assign iram_data_ok = w_pop && !w_head_d;
    assign dram_data_ok = w_pop && w_head_d;
    assign iram_rdata   = mem_rdata;
    assign dram_rdata   = mem_rdata;
    assign err          = r_err;

    // Owner storage carries no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_xfer)
            r_owner[r_wr_ptr] <= w_gnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock   <= 1'b0;
            r_lock_d <= 1'b0;
            r_starve <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_xfer)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_xfer && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_xfer && w_pop)
                r_count <= r_count - 1'b1;

            if (mem_data_ok && w_empty)
                r_err <= 1'b1;

            if (mem_req && !mem_addr_ok) begin
                r_lock   <= 1'b1;
                r_lock_d <= w_gnt_d;
            end else if (w_xfer || (r_lock && !w_lock_req)) begin
                r_lock <= 1'b0;
            end

            if (!iram_req || iram_addr_ok)
                r_starve <= '0;
            else if (dram_addr_ok && (r_starve != C_STARVE_MAX))
                r_starve <= r_starve + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Randomized bench for mem_arbiter: a transaction-level model predicts grants,
// forwarded fields and response routing; a small memory model supplies data.
module tb_mem_arbiter;

    localparam int XLEN         = 32;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              iram_req, iram_write, dram_req, dram_write;
    logic [XLEN/8-1:0] iram_wstrb, dram_wstrb;
    logic [XLEN-1:0]   iram_addr, iram_wdata, dram_addr, dram_wdata;
    logic              iram_addr_ok, iram_data_ok, dram_addr_ok, dram_data_ok;
    logic [XLEN-1:0]   iram_rdata, dram_rdata;
    logic              mem_req, mem_write;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_addr, mem_wdata;
    logic              mem_addr_ok, mem_data_ok;
    logic [XLEN-1:0]   mem_rdata;
    logic              err;

    mem_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
        .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_addr_ok(iram_addr_ok),
        .iram_data_ok(iram_data_ok), .iram_rdata(iram_rdata),
        .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_addr_ok(dram_addr_ok),
        .dram_data_ok(dram_data_ok), .dram_rdata(dram_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] val;
    } exp_t;

    // Transaction-level model state
    bit          lock_on, lock_owner_d;
    int          d_wins_while_i_waits;
    bit          owner_q[$];
    exp_t        i_pend[$], d_pend[$];
    logic [31:0] mem_resp_q[$];
    logic [31:0] mem_arr[16];
    bit          err_m;
    bit          i_acc, d_acc;
    int          p_req, p_drop, p_aok, p_dok;
    int          n_vec, n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_req(output logic wr, output logic [3:0] st, output logic [31:0] a,
                           output logic [31:0] wd);
        wr = 1'($urandom_range(0, 1));
        st = 4'($urandom);
        a  = 32'($urandom_range(0, 15)) << 2;
        wd = $urandom;
    endtask

    task automatic cycle(input bit do_rst, input bit spurious);
        bit          gd, greq, ereq, xfer, pop, sel_d, owner, was_empty, lreq;
        logic [31:0] v;
        exp_t        e;
        int          idx;
        @(posedge clk);
        #1;
        rst = do_rst;
        if (!iram_req || i_acc) begin
            iram_req = ($urandom_range(0, 99) < p_req);
            if (iram_req) new_req(iram_write, iram_wstrb, iram_addr, iram_wdata);
        end else if ($urandom_range(0, 99) < p_drop) iram_req = 1'b0;
        if (!dram_req || d_acc) begin
            dram_req = ($urandom_range(0, 99) < p_req);
            if (dram_req) new_req(dram_write, dram_wstrb, dram_addr, dram_wdata);
        end else if ($urandom_range(0, 99) < p_drop) dram_req = 1'b0;
        i_acc = 1'b0;
        d_acc = 1'b0;
        mem_addr_ok = ($urandom_range(0, 99) < p_aok);
        if (spurious) begin
            mem_data_ok = 1'b1;
            mem_rdata   = 32'hDEAD_BEEF;
        end else if (mem_resp_q.size() > 0 && $urandom_range(0, 99) < p_dok) begin
            mem_data_ok = 1'b1;
            mem_rdata   = mem_resp_q[0];
        end else begin
            mem_data_ok = 1'b0;
            mem_rdata   = $urandom;
        end
        #4;
        if (rst) begin
            chk("rst_mem_req", mem_req, 0);
            chk("rst_i_addr_ok", iram_addr_ok, 0);
            chk("rst_d_addr_ok", dram_addr_ok, 0);
            chk("rst_i_data_ok", iram_data_ok, 0);
            chk("rst_d_data_ok", dram_data_ok, 0);
            lock_on = 0;
            d_wins_while_i_waits = 0;
            owner_q.delete();
            i_pend.delete();
            d_pend.delete();
            mem_resp_q.delete();
            err_m = 0;
            return;
        end
        // Who holds the port this cycle
        if (lock_on) gd = lock_owner_d;
        else if (iram_req && dram_req) gd = (d_wins_while_i_waits < STARVE_LIMIT);
        else gd = dram_req;
        greq  = gd ? dram_req : iram_req;
        ereq  = greq && (owner_q.size() < DEPTH);
        xfer  = ereq && mem_addr_ok;
        sel_d = gd || !(iram_req || dram_req);
        chk("mem_req", mem_req, ereq);
        chk("i_addr_ok", iram_addr_ok, xfer && !gd);
        chk("d_addr_ok", dram_addr_ok, xfer && gd);
        chk("mem_addr", mem_addr, sel_d ? dram_addr : iram_addr);
        chk("mem_write", mem_write, sel_d ? dram_write : iram_write);
        chk("mem_wstrb", mem_wstrb, sel_d ? dram_wstrb : iram_wstrb);
        chk("mem_wdata", mem_wdata, sel_d ? dram_wdata : iram_wdata);
        chk("err", err, err_m);
        was_empty = (owner_q.size() == 0);
        pop = mem_data_ok && !was_empty;
        chk("i_data_ok", iram_data_ok, pop && !owner_q[0]);
        chk("d_data_ok", dram_data_ok, pop && owner_q[0]);
        if (mem_data_ok && was_empty) err_m = 1;
        if (pop) begin
            owner = owner_q.pop_front();
            void'(mem_resp_q.pop_front());
            e = owner ? d_pend.pop_front() : i_pend.pop_front();
            if (e.rd) begin
                if (owner) chk("d_rdata", dram_rdata, e.val);
                else       chk("i_rdata", iram_rdata, e.val);
            end
        end
        if (xfer) begin
            owner_q.push_back(gd);
            idx = int'(mem_addr[5:2]);
            if (sel_d ? dram_write : iram_write) begin
                for (int b = 0; b < 4; b++)
                    if ((sel_d ? dram_wstrb[b] : iram_wstrb[b]))
                        mem_arr[idx][8*b +: 8] = sel_d ? dram_wdata[8*b +: 8] : iram_wdata[8*b +: 8];
                e.rd = 0;
                v    = $urandom;
            end else begin
                e.rd = 1;
                v    = mem_arr[idx];
            end
            e.val = v;
            mem_resp_q.push_back(v);
            if (gd) begin d_pend.push_back(e); d_acc = 1; end
            else    begin i_pend.push_back(e); i_acc = 1; end
        end
        lreq = lock_owner_d ? dram_req : iram_req;
        if (ereq && !mem_addr_ok) begin
            lock_on      = 1;
            lock_owner_d = gd;
        end else if (xfer || (lock_on && !lreq)) begin
            lock_on = 0;
        end
        if (!iram_req || (xfer && !gd)) d_wins_while_i_waits = 0;
        else if (xfer && gd && d_wins_while_i_waits < STARVE_LIMIT) d_wins_while_i_waits++;
    endtask

    task automatic knobs(input int rq, input int dr, input int ao, input int dk);
        p_req = rq; p_drop = dr; p_aok = ao; p_dok = dk;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        iram_req = 0; iram_write = 0; iram_wstrb = '0; iram_addr = '0; iram_wdata = '0;
        dram_req = 0; dram_write = 0; dram_wstrb = '0; dram_addr = '0; dram_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
        i_acc = 0; d_acc = 0; lock_on = 0; lock_owner_d = 0; err_m = 0;
        d_wins_while_i_waits = 0;
        for (int k = 0; k < 16; k++) mem_arr[k] = '0;
        knobs(0, 100, 100, 100);
        repeat (2) cycle(1, 0);
        repeat (3) cycle(0, 0);
        // Continuous conflict with an always-ready memory
        knobs(100, 0, 100, 100);
        repeat (60) cycle(0, 0);
        // General random traffic with stalls and dropped requests
        knobs(60, 10, 50, 30);
        repeat (2000) cycle(0, 0);
        // Fill the owner queue
        knobs(80, 0, 100, 0);
        repeat (20) cycle(0, 0);
        knobs(80, 0, 100, 25);
        repeat (40) cycle(0, 0);
        // Drain, then an unsolicited response
        knobs(0, 100, 100, 100);
        repeat (15) cycle(0, 0);
        cycle(0, 1);
        repeat (3) cycle(0, 0);
        // Reset with transactions outstanding
        knobs(100, 0, 100, 0);
        repeat (3) cycle(0, 0);
        knobs(100, 0, 100, 100);
        cycle(1, 0);
        knobs(0, 100, 100, 100);
        repeat (2) cycle(0, 0);
        cycle(0, 1);
        repeat (2) cycle(0, 0);
        cycle(1, 0);
        // Random traffic with occasional resets
        knobs(70, 5, 60, 40);
        for (int n = 0; n < 600; n++) cycle(($urandom_range(0, 99) == 0), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
